// File: rtl/h_cmd_arb.sv
// ---------------------------------------------------------------------------
// h_cmd_arb
//
// Shares the single h command port among N_REQ requesters with round-robin
// arbitration. The index of every accepted command is pushed into an in-order
// tag FIFO. h answers in command order without an ID, so each response pops
// the FIFO head and is routed back to that requester as a registered one-hot
// strobe.
//
// Optional feature: define H_CMD_ARB_HIPRI_EN to give requester 0 strict
// priority. Grants to requester 0 then leave the RR pointer untouched, and the
// remaining requesters rotate among themselves.
//
// Ports
//   clk, arst_n                  clock, synchronous active-low reset
//   i_req_vld/opcode/k/v         per-requester command (payload flattened,
//                                requester i occupies slice [i*W +: W])
//   o_req_gnt                    one-hot accept, command consumed this cycle
//   o_cmd_vld_w/opcode/k/v       command towards h
//   i_cmd_rdy_w                  h ready
//   i_rsp_vld/status/v           response from h (in command order)
//   o_rsp_vld/status/v           registered response, o_rsp_vld one-hot
//   i_drain                      stop issuing new commands
//   o_idle                       drained and nothing outstanding
//   o_err_underflow              sticky: response seen with tag FIFO empty
//   o_state                      debug view of the control FSM
//
// Handshake: a command transfers on a cycle where o_cmd_vld_w and i_cmd_rdy_w
// are both high. o_cmd_vld_w never depends on i_cmd_rdy_w. A requester keeps
// its valid and payload stable until it sees its o_req_gnt bit.
// ---------------------------------------------------------------------------
module h_cmd_arb #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 8,
  parameter int OP_W      = 2,
  parameter int K_W       = 8,
  parameter int V_W       = 8,
  parameter int ST_W      = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [N_REQ-1:0]        i_req_vld,
  input  logic [N_REQ*OP_W-1:0]   i_req_opcode,
  input  logic [N_REQ*K_W-1:0]    i_req_k,
  input  logic [N_REQ*V_W-1:0]    i_req_v,
  output logic [N_REQ-1:0]        o_req_gnt,
  output logic                    o_cmd_vld_w,
  output logic [OP_W-1:0]         o_cmd_opcode_w,
  output logic [K_W-1:0]          o_cmd_k_w,
  output logic [V_W-1:0]          o_cmd_v_w,
  input  logic                    i_cmd_rdy_w,
  input  logic                    i_rsp_vld,
  input  logic [ST_W-1:0]         i_rsp_status,
  input  logic [V_W-1:0]          i_rsp_v,
  output logic [N_REQ-1:0]        o_rsp_vld,
  output logic [ST_W-1:0]         o_rsp_status,
  output logic [V_W-1:0]          o_rsp_v,
  input  logic                    i_drain,
  output logic                    o_idle,
  output logic                    o_err_underflow,
  output logic [1:0]              o_state
);

  localparam int RR_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_IDLE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   tags_q [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [ST_W-1:0]   rsp_status_q;
  logic [V_W-1:0]    rsp_v_q;
  logic              uf_q;

  logic              any_vld;
  logic [RR_W-1:0]   win;
  logic              fifo_full;
  logic              accept;
  logic              pop;

  // Requester index at a given offset from the RR pointer, wrapping at N_REQ.
  function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return RR_W'(s);
  endfunction

  // Arbitration: first valid requester at or after the pointer.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef H_CMD_ARB_HIPRI_EN
      // Requester 0 is served by the priority override below, not the ring.
      if (!any_vld && i_req_vld[rr_idx(rr_q, i)] && (rr_idx(rr_q, i) != '0)) begin
`else
      if (!any_vld && i_req_vld[rr_idx(rr_q, i)]) begin
`endif
        any_vld = 1'b1;
        win     = rr_idx(rr_q, i);
      end
    end
`ifdef H_CMD_ARB_HIPRI_EN
    if (i_req_vld[0]) begin
      any_vld = 1'b1;
      win     = '0;
    end
`endif
  end

  // Full is judged on the registered count: a pop this cycle does not
  // free a slot until the next cycle.
  assign fifo_full   = (cnt_q == CNT_W'(TAG_DEPTH));
  assign o_cmd_vld_w = any_vld && (state_q == S_RUN) && !fifo_full;
  assign accept      = o_cmd_vld_w && i_cmd_rdy_w;
  assign pop         = i_rsp_vld && (cnt_q != '0);

  always_comb begin
    o_cmd_opcode_w = '0;
    o_cmd_k_w      = '0;
    o_cmd_v_w      = '0;
    o_req_gnt      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == RR_W'(i)) begin
        o_cmd_opcode_w = i_req_opcode[i*OP_W +: OP_W];
        o_cmd_k_w      = i_req_k[i*K_W +: K_W];
        o_cmd_v_w      = i_req_v[i*V_W +: V_W];
        o_req_gnt[i]   = accept;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
`ifdef H_CMD_ARB_HIPRI_EN
    if (accept && (win != '0)) begin
`else
    if (accept) begin
`endif
      rr_d = (win == RR_W'(N_REQ - 1)) ? '0 : win + RR_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rsp_vld_d = '0;
    if (pop) rsp_vld_d[tags_q[rd_q]] = 1'b1;
  end

  // Control FSM. DRAIN only settles to IDLE once nothing is outstanding and
  // no response is arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (i_drain) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!i_drain)                         state_d = S_RUN;
        else if ((cnt_q == '0) && !i_rsp_vld) state_d = S_IDLE;
      end
      S_IDLE:  if (!i_drain) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= S_RUN;
      rr_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      rsp_vld_q    <= '0;
      rsp_status_q <= '0;
      rsp_v_q      <= '0;
      uf_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      if (accept) wr_q <= wr_q + PTR_W'(1);
      if (pop) begin
        rd_q         <= rd_q + PTR_W'(1);
        rsp_status_q <= i_rsp_status;
        rsp_v_q      <= i_rsp_v;
      end
      if (i_rsp_vld && (cnt_q == '0)) uf_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (accept) tags_q[wr_q] <= win;
  end

  assign o_rsp_vld       = rsp_vld_q;
  assign o_rsp_status    = rsp_status_q;
  assign o_rsp_v         = rsp_v_q;
  assign o_idle          = (state_q == S_IDLE);
  assign o_err_underflow = uf_q;
  assign o_state         = state_q;

endmodule
